// File: rtl/miriscv_irq_pkg.sv
// Shared types and helpers for the miriscv interrupt controller and related blocks.
package miriscv_irq_pkg;

   localparam int IRQ_MAX_SRC = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

   // Width of a source index; never below 1 so a single-source build still has an id port.
   function automatic int irq_id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/miriscv_irq_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module miriscv_irq_prio_enc #(
   parameter int N    = 32,
   parameter int ID_W = 5
) (
   input  logic [N-1:0]    req,
   output logic            valid,
   output logic [ID_W-1:0] idx
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = ID_W'(i);
      end
   end

endmodule

// File: rtl/miriscv_irq_ctrl.sv
// Interrupt controller: synchronises sources, captures edge/level requests, masks them
// and hands the lowest pending index to the core via a request/ack/return handshake.
module miriscv_irq_ctrl
   import miriscv_irq_pkg::*;
#(
   parameter int          N_SRC       = 32,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] EDGE_MASK   = 32'h0,
   localparam int         ID_W        = irq_id_w(N_SRC)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [N_SRC-1:0] int_req_i,
   input  logic             mask_we_i,
   input  logic [N_SRC-1:0] mask_wdata_i,
   output logic [N_SRC-1:0] mask_o,
   output logic [N_SRC-1:0] pending_o,
   output logic             irq_o,
   output logic [ID_W-1:0]  irq_id_o,
   input  logic             irq_ack_i,
   input  logic             irq_ret_i
);

   logic [N_SRC-1:0] sync;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] eligible;
   logic [N_SRC-1:0] mask_reg;
   logic             irq_reg;
   logic [ID_W-1:0]  irq_id_reg;
   logic [ID_W-1:0]  win_id;
   logic             win_valid;
   logic             ack_fire;
   irq_state_e       state_reg;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign sync = int_req_i;
      end else begin : g_sync
         logic [N_SRC-1:0] sync_reg [SYNC_STAGES];
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
            end else begin
               sync_reg[0] <= int_req_i;
               for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
            end
         end
         assign sync = sync_reg[SYNC_STAGES-1];
      end
   endgenerate

   assign ack_fire = (state_reg == REQ) && irq_ack_i;

   // Edge sources hold a sticky bit (new edge beats the ack clear); level sources follow sync.
   genvar gi;
   generate
      for (gi = 0; gi < N_SRC; gi++) begin : g_src
         if (EDGE_MASK[gi]) begin : g_edge
            logic sync_d_reg;
            logic pend_reg;
            logic clr;
            assign clr = ack_fire && (irq_id_reg == ID_W'(gi));
            always_ff @(posedge clk_i or negedge rst_n_i) begin
               if (!rst_n_i) begin
                  sync_d_reg <= 1'b0;
                  pend_reg   <= 1'b0;
               end else begin
                  sync_d_reg <= sync[gi];
                  pend_reg   <= (sync[gi] & ~sync_d_reg) | (pend_reg & ~clr);
               end
            end
            assign pending[gi] = pend_reg;
         end else begin : g_level
            assign pending[gi] = sync[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mask_reg <= '0;
      end else if (mask_we_i) begin
         mask_reg <= mask_wdata_i;
      end
   end

   assign eligible = pending & mask_reg;

   miriscv_irq_prio_enc #(
      .N    (N_SRC),
      .ID_W (ID_W)
   ) u_prio_enc (
      .req   (eligible),
      .valid (win_valid),
      .idx   (win_id)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg  <= IDLE;
         irq_reg    <= 1'b0;
         irq_id_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (win_valid) begin
                  irq_id_reg <= win_id;
                  irq_reg    <= 1'b1;
                  state_reg  <= REQ;
               end
            end
            REQ: begin
               // Acknowledge wins over a simultaneous withdrawal.
               if (irq_ack_i) begin
                  irq_reg   <= 1'b0;
                  state_reg <= SERVICE;
               end else if (!eligible[irq_id_reg]) begin
                  irq_reg   <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            SERVICE: begin
               if (irq_ret_i) state_reg <= IDLE;
            end
            default: begin
               irq_reg   <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign mask_o    = mask_reg;
   assign pending_o = pending;
   assign irq_o     = irq_reg;
   assign irq_id_o  = irq_id_reg;

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// Randomised and directed checks of miriscv_irq_ctrl against a cycle-level behavioural model.
module tb_miriscv_irq_ctrl;

   localparam int          N    = 8;
   localparam logic [7:0]  EDGE = 8'hFE;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] int_req;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic [7:0] mask_o;
   logic [7:0] pending_o;
   logic       irq_o;
   logic [2:0] irq_id_o;
   logic       irq_ack;
   logic       irq_ret;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: two-deep input delay line, previous sync for edges, sticky edge bits, mask, handshake.
   logic [7:0] m_stage1, m_sync, m_sync_d, m_pend_e, m_mask;
   logic       m_req, m_svc;
   int         m_id;

   always #5 clk = ~clk;

   miriscv_irq_ctrl #(
      .N_SRC       (N),
      .SYNC_STAGES (2),
      .EDGE_MASK   (32'h0000_00FE)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .int_req_i    (int_req),
      .mask_we_i    (mask_we),
      .mask_wdata_i (mask_wdata),
      .mask_o       (mask_o),
      .pending_o    (pending_o),
      .irq_o        (irq_o),
      .irq_id_o     (irq_id_o),
      .irq_ack_i    (irq_ack),
      .irq_ret_i    (irq_ret)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_stage1 = '0; m_sync = '0; m_sync_d = '0; m_pend_e = '0; m_mask = '0;
      m_req = 1'b0; m_svc = 1'b0; m_id = 0;
   endtask

   task automatic model_edge();
      logic [7:0] elig, edge_set, clr;
      elig     = (m_pend_e | (m_sync & ~EDGE)) & m_mask;
      edge_set = m_sync & ~m_sync_d & EDGE;
      clr      = '0;
      if (m_req) begin
         if (irq_ack) begin
            clr[m_id] = 1'b1;
            m_req = 1'b0;
            m_svc = 1'b1;
         end else if (!elig[m_id]) begin
            m_req = 1'b0;
         end
      end else if (m_svc) begin
         if (irq_ret) m_svc = 1'b0;
      end else if (elig != 0) begin
         m_id  = lowest(elig);
         m_req = 1'b1;
      end
      m_pend_e = edge_set | (m_pend_e & ~clr);
      m_sync_d = m_sync;
      m_sync   = m_stage1;
      m_stage1 = int_req;
      if (mask_we) m_mask = mask_wdata;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("irq", 32'(irq_o), 32'(m_req));
      check("id", 32'(irq_id_o), m_id);
      check("pending", 32'(pending_o), 32'(m_pend_e | (m_sync & ~EDGE)));
      check("mask", 32'(mask_o), 32'(m_mask));
   endtask

   task automatic write_mask(input logic [7:0] v);
      mask_we = 1'b1; mask_wdata = v;
      tick();
      mask_we = 1'b0;
   endtask

   task automatic do_ack();
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
   endtask

   task automatic do_ret();
      irq_ret = 1'b1; tick(); irq_ret = 1'b0;
   endtask

   task automatic pulse(input int src);
      int_req[src] = 1'b1; tick(); int_req[src] = 1'b0;
   endtask

   task automatic wait_irq(output int cycles);
      cycles = 0;
      while (!irq_o && cycles < 30) begin
         tick();
         cycles++;
      end
      check("irq_timeout", 32'(irq_o), 32'd1);
   endtask

   initial begin
      int c;
      rst_n = 1'b0; int_req = '0; mask_we = 1'b0; mask_wdata = '0;
      irq_ack = 1'b0; irq_ret = 1'b0;
      model_reset();
      #3;
      check("rst_irq", 32'(irq_o), 0);
      check("rst_id", 32'(irq_id_o), 0);
      check("rst_mask", 32'(mask_o), 0);
      check("rst_pending", 32'(pending_o), 0);
      @(negedge clk); rst_n = 1'b1;

      $display("[TB] edge capture and 2-stage latency on source 3");
      write_mask(8'h08);
      int_req[3] = 1'b1; tick(); int_req[3] = 1'b0;
      wait_irq(c);
      check("edge_latency", c + 1, 4);
      check("edge_id", 32'(irq_id_o), 3);
      do_ack();
      check("ack_pend", 32'(pending_o[3]), 0);
      check("ack_irq", 32'(irq_o), 0);
      do_ret();
      repeat (3) tick();
      check("ret_no_irq", 32'(irq_o), 0);

      $display("[TB] priority hold: id 5 held while source 2 arrives");
      write_mask(8'hFF);
      pulse(5);
      wait_irq(c);
      check("prio_first", 32'(irq_id_o), 5);
      pulse(2);
      repeat (4) tick();
      check("hold_id", 32'(irq_id_o), 5);
      do_ack(); do_ret();
      wait_irq(c);
      check("next_id", 32'(irq_id_o), 2);
      do_ack(); do_ret();

      $display("[TB] level re-request and withdrawal on source 0");
      write_mask(8'h01);
      int_req[0] = 1'b1;
      wait_irq(c);
      check("lvl_id", 32'(irq_id_o), 0);
      do_ack(); tick(); tick();
      do_ret();
      wait_irq(c);
      check("lvl_rereq_lat", c + 1, 2);
      check("lvl_rereq_id", 32'(irq_id_o), 0);
      int_req[0] = 1'b0;
      repeat (4) tick();
      check("lvl_withdraw", 32'(irq_o), 0);

      $display("[TB] masked capture on source 4");
      write_mask(8'h00);
      pulse(4);
      repeat (4) tick();
      check("masked_pend", 32'(pending_o[4]), 1);
      check("masked_irq", 32'(irq_o), 0);
      write_mask(8'h10);
      tick();
      check("unmask_irq", 32'(irq_o), 1);
      check("unmask_id", 32'(irq_id_o), 4);

      $display("[TB] collision: new edge on source 4 during its acknowledge");
      int_req[4] = 1'b1; tick(); int_req[4] = 1'b0; tick();
      do_ack();
      check("collision_pend", 32'(pending_o[4]), 1);
      check("collision_irq", 32'(irq_o), 0);
      do_ret();
      wait_irq(c);
      check("collision_id", 32'(irq_id_o), 4);
      do_ack(); do_ret();

      $display("[TB] randomised traffic");
      for (int i = 0; i < 400; i++) begin
         int_req    = 8'($urandom & $urandom & $urandom);
         mask_we    = ($urandom_range(0, 15) == 0);
         mask_wdata = 8'($urandom);
         irq_ack    = ($urandom_range(0, 3) == 0);
         irq_ret    = ($urandom_range(0, 3) == 0);
         tick();
      end
      int_req = '0; mask_we = 1'b0; irq_ack = 1'b0; irq_ret = 1'b0;

      $display("[TB] asynchronous reset during SERVICE");
      write_mask(8'hFF);
      do_ret();
      repeat (3) tick();
      if (irq_o) begin
         do_ack(); do_ret();
      end
      pulse(6);
      wait_irq(c);
      do_ack();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("arst_irq", 32'(irq_o), 0);
      check("arst_id", 32'(irq_id_o), 0);
      check("arst_mask", 32'(mask_o), 0);
      check("arst_pending", 32'(pending_o), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (5) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/miriscv_irq_ctrl.md
# miriscv_irq_ctrl

Parametrised interrupt controller between the external `int_req` lines and the miriscv core. It synchronises up to 32 sources and latches per-source edge or level requests. It applies a software mask, picks the lowest-index pending source and presents it to the core through a request/acknowledge/return handshake. It supersedes the flat 32-bit `int_req_i` wiring with masking, edge capture and a defined service cycle.

## Interface
- `N_SRC`, default 32: number of interrupt sources, 1..32.
- `SYNC_STAGES`, default 2: synchroniser flops per source, 0..3. A value of 0 means sources are already synchronous to `clk_i`.
- `EDGE_MASK`, default 32'h0: per-source mode. Bit 1 selects rising-edge capture, bit 0 selects level. Bits at or above `N_SRC` are ignored.
- `clk_i` in 1: single clock; all logic is on the rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `int_req_i` in `N_SRC`: raw interrupt sources.
- `mask_we_i` in 1: write strobe for the mask register.
- `mask_wdata_i` in `N_SRC`: mask write data. A 1 enables the source.
- `mask_o` out `N_SRC`: current mask (mie view).
- `pending_o` out `N_SRC`: current pending vector (mip view).
- `irq_o` out 1: interrupt request to the core.
- `irq_id_o` out `ID_W`: index of the requested source. `ID_W` is max(1, clog2(`N_SRC`)).
- `irq_ack_i` in 1: core accepts the request (trap entry).
- `irq_ret_i` in 1: core finished the handler (mret).

## Operation
- **Synchroniser:** `SYNC_STAGES` flops per source produce `sync`. Edge-mode sources keep one extra flop `sync_d` for edge detection.
- **Pending, edge mode:** the bit sets when `sync & ~sync_d`. It clears when the source is acknowledged. If a new edge and the acknowledge occur in the same cycle, set wins. Edge capture continues while the source is masked.
- **Pending, level mode:** `pending` equals `sync` and holds no state. An acknowledge has no effect on it.
- **Mask:** the mask is written on `mask_we_i`, with no write-enable per bit.
- **Selection:** the eligible set is `pending & mask`. The lowest set index wins.
- **IDLE:**
  - `irq_o` is 0.
  - If the eligible set is non-zero, latch the winner into `irq_id_o` and go to REQ.
- **REQ:**
  - `irq_o` is 1 and `irq_id_o` is held stable, even if a lower index becomes eligible.
  - On `irq_ack_i`, clear the edge pending bit of `irq_id_o` and go to SERVICE.
  - If the latched source is no longer eligible and `irq_ack_i` is 0, go to IDLE; this withdraws the request. Causes are an unmasked bit being written to 0, or a level source dropping.
  - An acknowledge has priority over withdrawal in the same cycle.
- **SERVICE:**
  - `irq_o` is 0 and `irq_id_o` holds the serviced id.
  - On `irq_ret_i`, go to IDLE.
  - There is no nesting: new pending sources wait.
- **Ignored inputs:** `irq_ack_i` outside REQ and `irq_ret_i` outside SERVICE are ignored.
- **Level re-request:** a level source still high at return requests again.

## Timing
- **Reset values:** `irq_o`=0, `irq_id_o`=0, `mask_o`=0, `pending_o`=0. State is IDLE and all synchroniser flops are 0.
- **Request latency:** a source is first sampled high at edge k. With `SYNC_STAGES`=0, `pending_o` is 1 after edge k and `irq_o` is 1 after edge k+1. Each synchroniser stage adds one cycle.
- **Mask latency:** a mask write at edge k affects eligibility from cycle k+1. An IDLE→REQ transition can therefore occur at edge k+1.
- **Acknowledge:** `irq_o` falls, and the edge pending bit clears, after the acknowledging edge.
- **Return:** the earliest next request is `irq_o` high 2 edges after the `irq_ret_i` edge, i.e. SERVICE→IDLE then IDLE→REQ.
- **Mid-operation reset:** reset asserted at any point returns everything to reset values asynchronously. Edges captured before reset are lost.

## Structure
- **Package `miriscv_irq_pkg`:**
  - state enum `irq_state_e` with IDLE, REQ, SERVICE
  - `IRQ_MAX_SRC`=32
  - function `irq_id_w(n)`
- **Sub-module `miriscv_irq_prio_enc`:** parametrised lowest-index priority encoder. Outputs a valid flag and an index; reused by the future PLIC-style block.
- **Top level:** synchroniser, pending and mask registers, and the FSM are inline.

## Test plan
- **Edge capture:** `N_SRC`=8, `SYNC_STAGES`=0, `EDGE_MASK`=8'hFF, mask=8'h08. Pulse `int_req_i[3]` for 1 cycle → `pending_o`=8'h08, then `irq_o`=1 with `irq_id_o`=3 one edge later. Acknowledge → `pending_o`=0. Return → `irq_o` stays 0.
- **Priority and hold:** in REQ with id=5, make source 2 eligible → `irq_id_o` stays 5. After acknowledge and return, the next request carries id=2.
- **Level re-request:** `EDGE_MASK`=0, source 0 held high through the handler. Return → `irq_o` rises again 2 edges later with id=0. Drop the source while in REQ → back to IDLE, `irq_o`=0.
- **Masked capture:** edge source 4 pulses while masked → `pending_o[4]`=1, `irq_o`=0. Write mask bit 4 → `irq_o`=1 with id=4.
- **Collision:** a new edge on the acknowledged source in the acknowledge cycle → `pending_o` bit remains 1.
- **Synchroniser and reset:**
  - With `SYNC_STAGES`=2, a request shows `irq_o` latency of exactly 4 edges.
  - Asserting `rst_n_i`=0 during SERVICE zeroes all outputs immediately, without waiting for a clock edge.
